// File: rtl/tl_pkg.sv
// Shared constants for the traffic-light lamp monitor: lamp codes, phase ids,
// fault codes, FSM state encoding and the legal phase-pattern table.
package tl_pkg;

  localparam logic [2:0] LAMP_OFF   = 3'b000;
  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_RED   = 3'b100;

  localparam int NUM_PHASES = 6;

  localparam logic [2:0] P0         = 3'd0;
  localparam logic [2:0] P1         = 3'd1;
  localparam logic [2:0] P2         = 3'd2;
  localparam logic [2:0] P3         = 3'd3;
  localparam logic [2:0] P4         = 3'd4;
  localparam logic [2:0] P5         = 3'd5;
  localparam logic [2:0] PHASE_NONE = 3'd7;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_SEQUENCE = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_LONG     = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SYNC   = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;
  localparam state_t ST_FAULT  = 2'd3;

  // Lamp word layout is {m1, mt, m2, s}; entry i is the pattern of phase i.
  localparam logic [NUM_PHASES-1:0][11:0] PHASE_TABLE = {
    {LAMP_RED,   LAMP_RED,   LAMP_RED,   LAMP_AMBER},  // P5
    {LAMP_RED,   LAMP_RED,   LAMP_RED,   LAMP_GREEN},  // P4
    {LAMP_AMBER, LAMP_AMBER, LAMP_RED,   LAMP_RED},    // P3
    {LAMP_GREEN, LAMP_GREEN, LAMP_RED,   LAMP_RED},    // P2
    {LAMP_GREEN, LAMP_RED,   LAMP_AMBER, LAMP_RED},    // P1
    {LAMP_GREEN, LAMP_RED,   LAMP_GREEN, LAMP_RED}     // P0
  };

  // Legal successor of a phase in the fixed P0..P5 cycle.
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return (p == P5) ? P0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/tl_pattern_decode.sv
// Combinational decode of the four lamp codes into a phase id plus
// legal / all-off / conflicting-green flags.
module tl_pattern_decode
  import tl_pkg::*;
(
  input  logic [11:0] lamps_i,
  output logic [2:0]  phase_o,
  output logic        legal_o,
  output logic        off_o,
  output logic        conflict_o
);

  logic [2:0] m1, mt, m2, s;
  assign {m1, mt, m2, s} = lamps_i;

  // Table lookup: at most one entry can match since all patterns differ.
  always_comb begin
    phase_o = PHASE_NONE;
    legal_o = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (lamps_i == PHASE_TABLE[i]) begin
        phase_o = 3'(i);
        legal_o = 1'b1;
      end
    end
  end

  assign off_o = (lamps_i == 12'h000);

  // All-off is a controller reset, not a conflict, even though s is non-red.
  assign conflict_o = !off_o &&
                      (((s != LAMP_RED) && ((m1 != LAMP_RED) || (mt != LAMP_RED) || (m2 != LAMP_RED))) ||
                       ((mt != LAMP_RED) && (m2 != LAMP_RED)));

endmodule

// File: rtl/tl_lamp_monitor.sv
// Passive lamp monitor: samples the lamp outputs, locks onto the phase cycle,
// checks order and dwell times and latches the first fault with its code.
// Handshake: none; every output is a plain registered level (phase_change is
// a one-cycle pulse) reflecting the lamp sample taken one edge earlier.
module tl_lamp_monitor
  import tl_pkg::*;
#(
  parameter int GREEN_CYCLES = 8,
  parameter int AMBER_CYCLES = 3,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       m1,
  input  logic [2:0]       mt,
  input  logic [2:0]       m2,
  input  logic [2:0]       s,
  input  logic             clr_fault,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             phase_change,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             conflict,
  output logic [CNT_W-1:0] dwell,
  output logic [1:0]       dbg_state_o
);

  localparam logic [CNT_W-1:0] GREEN_EXP = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] AMBER_EXP = CNT_W'(AMBER_CYCLES);

  logic [11:0]      lamp_q, prev_q;
  logic             conflict_q;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic             pc_q, pc_d;
  logic [2:0]       code_q, code_d;

  logic [2:0]       dec_phase;
  logic             dec_legal, dec_off, dec_conflict;
  logic             same_pat;
  logic [CNT_W-1:0] exp_dwell;
  logic [2:0]       new_code;

  tl_pattern_decode u_decode (
    .lamps_i    (lamp_q),
    .phase_o    (dec_phase),
    .legal_o    (dec_legal),
    .off_o      (dec_off),
    .conflict_o (dec_conflict)
  );

  // A zero dwell means nothing has been counted yet, so the sample is new.
  assign same_pat  = (lamp_q == prev_q) && (dwell_q != '0);
  assign exp_dwell = phase_q[0] ? AMBER_EXP : GREEN_EXP;

  // Dwell counter: restart at 1 on a new pattern, saturate at all-ones.
  always_comb begin
    dwell_d = CNT_W'(1);
    if (same_pat) dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
  end

  // Sequence FSM and fault detection on the registered lamp sample.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pc_d     = 1'b0;
    code_d   = code_q;
    new_code = FC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (dec_conflict)           new_code = FC_CONFLICT;
        else if (!dec_legal && !dec_off) new_code = FC_ILLEGAL;
        else if (dec_legal) begin
          state_d = ST_SYNC;
          phase_d = dec_phase;
        end
      end
      ST_SYNC, ST_LOCKED: begin
        if (dec_conflict)           new_code = FC_CONFLICT;
        else if (!dec_legal && !dec_off) new_code = FC_ILLEGAL;
        else if (dec_off) begin
          state_d = ST_IDLE;
          phase_d = PHASE_NONE;
        end else if (dec_phase != phase_q) begin
          if (dec_phase != next_phase(phase_q)) new_code = FC_SEQUENCE;
          // The sync phase may run long after controller reset, so only
          // dwells measured while locked are checked.
          else if ((state_q == ST_LOCKED) && (dwell_q < exp_dwell)) new_code = FC_SHORT;
          else begin
            state_d = ST_LOCKED;
            phase_d = dec_phase;
            pc_d    = 1'b1;
          end
        end else if ((state_q == ST_LOCKED) && (dwell_q == exp_dwell)) begin
          new_code = FC_LONG;
        end
      end
      default: begin
        if (clr_fault) begin
          state_d = ST_IDLE;
          phase_d = PHASE_NONE;
          code_d  = FC_NONE;
        end
      end
    endcase
    // A clear arriving with a fresh fault wins; the pattern is re-judged from IDLE.
    if (new_code != FC_NONE) begin
      if (clr_fault) begin
        state_d = ST_IDLE;
        phase_d = PHASE_NONE;
      end else begin
        state_d = ST_FAULT;
        code_d  = new_code;
      end
    end
  end

  // Lamp sample pipeline, conflict flag and dwell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_q     <= '0;
      prev_q     <= '0;
      conflict_q <= 1'b0;
      dwell_q    <= '0;
    end else begin
      lamp_q     <= {m1, mt, m2, s};
      prev_q     <= lamp_q;
      conflict_q <= dec_conflict;
      dwell_q    <= dwell_d;
    end
  end

  // FSM state, phase, change pulse and fault code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= PHASE_NONE;
      pc_q    <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
    end
  end

  assign phase        = phase_q;
  assign locked       = (state_q == ST_LOCKED);
  assign fault        = (state_q == ST_FAULT);
  assign phase_change = pc_q;
  assign fault_code   = code_q;
  assign conflict     = conflict_q;
  assign dwell        = dwell_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tl_lamp_monitor.sv
// Bench for tl_lamp_monitor: directed scenarios plus a randomized lamp stream,
// all checked against a sample-level behavioural model of the monitor.
module tb_tl_lamp_monitor;

  localparam int GREEN_CYCLES = 8;
  localparam int AMBER_CYCLES = 3;
  localparam int CNT_W        = 5;
  localparam int DWELL_MAX    = (1 << CNT_W) - 1;

  localparam logic [2:0] C_G = 3'b001;
  localparam logic [2:0] C_A = 3'b010;
  localparam logic [2:0] C_R = 3'b100;
  localparam logic [11:0] CONF_PAT   = {C_G, C_R, C_R, C_G};
  localparam logic [11:0] ALLRED_PAT = {C_R, C_R, C_R, C_R};
  localparam logic [14:0] RESET_VEC  = {3'd7, 12'd0};

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] m1 = '0, mt = '0, m2 = '0, s = '0;
  logic clr_fault = 1'b0;
  logic [2:0] phase, fault_code;
  logic locked, phase_change, fault, conflict;
  logic [CNT_W-1:0] dwell;
  logic [1:0] dbg_state;
  logic [14:0] act_vec;

  always #5 clk = ~clk;

  tl_lamp_monitor #(.GREEN_CYCLES(GREEN_CYCLES), .AMBER_CYCLES(AMBER_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .m1(m1), .mt(mt), .m2(m2), .s(s), .clr_fault(clr_fault),
    .phase(phase), .locked(locked), .phase_change(phase_change), .fault(fault),
    .fault_code(fault_code), .conflict(conflict), .dwell(dwell), .dbg_state_o(dbg_state)
  );

  assign act_vec = {phase, locked, phase_change, fault, fault_code, conflict, dwell};

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  function automatic logic [11:0] pat(input int p);
    case (p)
      0:       return {C_G, C_R, C_G, C_R};
      1:       return {C_G, C_R, C_A, C_R};
      2:       return {C_G, C_G, C_R, C_R};
      3:       return {C_A, C_A, C_R, C_R};
      4:       return {C_R, C_R, C_R, C_G};
      default: return {C_R, C_R, C_R, C_A};
    endcase
  endfunction

  function automatic int need(input int p);
    return (p % 2 == 1) ? AMBER_CYCLES : GREEN_CYCLES;
  endfunction

  function automatic int decode(input logic [11:0] l);
    for (int p = 0; p < 6; p++) if (l == pat(p)) return p;
    return 7;
  endfunction

  function automatic bit is_conflict(input logic [11:0] l);
    logic [2:0] a, t, b, c;
    {a, t, b, c} = l;
    if (l == 12'h000) return 1'b0;
    return ((c != C_R) && ((a != C_R) || (t != C_R) || (b != C_R))) || ((t != C_R) && (b != C_R));
  endfunction

  logic [11:0] mdl_lamp_q, mdl_prev;
  int mdl_run, mdl_phase, mdl_code;
  bit mdl_synced, mdl_locked, mdl_pc, mdl_conf;

  task automatic model_reset();
    mdl_lamp_q = '0; mdl_prev = '0; mdl_run = 0; mdl_phase = 7; mdl_code = 0;
    mdl_synced = 0; mdl_locked = 0; mdl_pc = 0; mdl_conf = 0;
  endtask

  // One clock edge: judge the sample registered at the previous edge.
  task automatic model_edge(input bit clr);
    logic [11:0] smp;
    int old_run, p, nc;
    smp = mdl_lamp_q;
    old_run = mdl_run;
    if (smp == mdl_prev && mdl_run > 0) begin
      if (mdl_run < DWELL_MAX) mdl_run++;
    end else mdl_run = 1;
    mdl_prev = smp;
    mdl_conf = is_conflict(smp);
    mdl_pc = 0;
    nc = 0;
    p = decode(smp);
    if (mdl_code != 0) begin
      if (clr) begin mdl_code = 0; mdl_phase = 7; end
    end else begin
      if (mdl_conf) nc = 2;
      else if (p == 7 && smp != 12'h000) nc = 1;
      else if (!mdl_synced) begin
        if (p != 7) begin mdl_synced = 1; mdl_phase = p; end
      end else if (smp == 12'h000) begin
        mdl_synced = 0; mdl_locked = 0; mdl_phase = 7;
      end else if (p != mdl_phase) begin
        if (p != (mdl_phase + 1) % 6) nc = 3;
        else if (mdl_locked && old_run < need(mdl_phase)) nc = 4;
        else begin mdl_locked = 1; mdl_phase = p; mdl_pc = 1; end
      end else if (mdl_locked && old_run == need(mdl_phase)) nc = 5;
      if (nc != 0) begin
        mdl_synced = 0; mdl_locked = 0;
        if (clr) mdl_phase = 7;
        else mdl_code = nc;
      end
    end
  endtask

  function automatic logic [14:0] exp_vec();
    return {3'(mdl_phase), mdl_locked, mdl_pc, (mdl_code != 0), 3'(mdl_code), mdl_conf, CNT_W'(mdl_run)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    {m1, mt, m2, s} = 12'h000;
    clr_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Drive one lamp sample (and clear) for one clock; returns 1 time unit after the edge.
  task automatic drive_cycle(input logic [11:0] l, input bit clr);
    {m1, mt, m2, s} = l;
    clr_fault = clr;
    @(posedge clk);
    model_edge(clr);
    mdl_lamp_q = l;
    #1;
    clr_fault = 1'b0;
  endtask

  task automatic run(input int p, input int n);
    for (int k = 0; k < n; k++) drive_cycle(pat(p), 1'b0);
  endtask

  task automatic run_pat(input logic [11:0] l, input int n);
    for (int k = 0; k < n; k++) drive_cycle(l, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (act_vec !== RESET_VEC) $display("FAIL reset_outputs: got %h want %h", act_vec, RESET_VEC);
    else n_pass++;
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int pulses = 0;
    do_reset();
    for (int seg = 0; seg < 19; seg++) begin
      int p, n;
      p = seg % 6;
      n = (seg == 0) ? GREEN_CYCLES + 1 : need(p);
      for (int k = 0; k < n; k++) begin
        drive_cycle(pat(p), 1'b0);
        n_checks++;
        if (act_vec !== exp_vec()) $display("FAIL nominal seg %0d: got %h want %h", seg, act_vec, exp_vec());
        else n_pass++;
        pulses += int'(phase_change);
      end
    end
    n_checks++;
    if (pulses != 18) $display("FAIL nominal_pulses: got %0d want 18", pulses);
    else n_pass++;
    n_checks++;
    if ({locked, fault, phase} !== {1'b1, 1'b0, 3'd0}) $display("FAIL nominal_end: got %b want 10000", {locked, fault, phase});
    else n_pass++;
  endtask

  task automatic test_conflict();
    do_reset();
    run(0, 9); run(1, 3); run(2, 8); run(3, 3); run(4, 4);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL conflict_prelock: got %0d want 1", locked);
    else n_pass++;
    run_pat(CONF_PAT, 2);
    n_checks++;
    if ({conflict, fault, fault_code, locked} !== {1'b1, 1'b1, 3'd2, 1'b0})
      $display("FAIL conflict_flag: got %b want 110100", {conflict, fault, fault_code, locked});
    else n_pass++;
    n_checks++;
    if (act_vec !== exp_vec()) $display("FAIL conflict_model: got %h want %h", act_vec, exp_vec());
    else n_pass++;
    run_pat(CONF_PAT, 3);
    n_checks++;
    if ({fault, fault_code, phase} !== {1'b1, 3'd2, 3'd4}) $display("FAIL conflict_sticky: got %b want 1010100", {fault, fault_code, phase});
    else n_pass++;
    drive_cycle(pat(4), 1'b0);
    drive_cycle(pat(4), 1'b1);
    n_checks++;
    if ({fault, fault_code, phase, locked} !== {1'b0, 3'd0, 3'd7, 1'b0}) $display("FAIL conflict_clear: got %b want 00001110", {fault, fault_code, phase, locked});
    else n_pass++;
    drive_cycle(pat(4), 1'b0);
    n_checks++;
    if (act_vec !== exp_vec()) $display("FAIL conflict_resync: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_long();
    do_reset();
    run(0, 9); run(1, 3); run(2, 9);
    n_checks++;
    if (fault !== 1'b0) $display("FAIL long_green_edge: got %0d want 0", fault);
    else n_pass++;
    run(2, 1);
    n_checks++;
    if ({fault, fault_code} !== {1'b1, 3'd5}) $display("FAIL long_green: got %b want 1101", {fault, fault_code});
    else n_pass++;
    do_reset();
    run(0, 9); run(1, 4);
    n_checks++;
    if (fault !== 1'b0) $display("FAIL long_amber_edge: got %0d want 0", fault);
    else n_pass++;
    run(1, 1);
    n_checks++;
    if ({fault, fault_code, phase} !== {1'b1, 3'd5, 3'd1}) $display("FAIL long_amber: got %b want 1101001", {fault, fault_code, phase});
    else n_pass++;
  endtask

  task automatic test_short_seq();
    do_reset();
    run(0, 9); run(1, 3); run(2, 8); run(3, 3); run(4, 8); run(5, 3); run(0, 7); run(1, 1);
    n_checks++;
    if (fault !== 1'b0) $display("FAIL short_pre: got %0d want 0", fault);
    else n_pass++;
    run(1, 1);
    n_checks++;
    if ({fault, fault_code, phase} !== {1'b1, 3'd4, 3'd0}) $display("FAIL short_code: got %b want 1100000", {fault, fault_code, phase});
    else n_pass++;
    do_reset();
    run(0, 9); run(1, 3); run(3, 2);
    n_checks++;
    if ({fault, fault_code, phase} !== {1'b1, 3'd3, 3'd1}) $display("FAIL sequence_code: got %b want 1011001", {fault, fault_code, phase});
    else n_pass++;
  endtask

  task automatic test_off();
    do_reset();
    run(0, 9); run(1, 3); run(2, 3);
    run_pat(12'h000, 2);
    n_checks++;
    if ({locked, fault, phase} !== {1'b0, 1'b0, 3'd7}) $display("FAIL off_idle: got %b want 00111", {locked, fault, phase});
    else n_pass++;
    run(0, 8); run(1, 2);
    n_checks++;
    if ({locked, phase_change, phase} !== {1'b1, 1'b1, 3'd1}) $display("FAIL off_relock: got %b want 11001", {locked, phase_change, phase});
    else n_pass++;
    n_checks++;
    if (act_vec !== exp_vec()) $display("FAIL off_model: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    run(0, 9); run(1, 3); run(2, 4);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (act_vec !== RESET_VEC) $display("FAIL async_reset: got %h want %h", act_vec, RESET_VEC);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_priority();
    do_reset();
    run(0, 9); run(1, 3); run(2, 8); run(3, 3); run(4, 8); run(5, 3); run(0, 7); run(1, 2);
    run_pat(CONF_PAT, 3);
    n_checks++;
    if ({conflict, fault_code} !== {1'b1, 3'd4}) $display("FAIL prio_keep_first: got %b want 1100", {conflict, fault_code});
    else n_pass++;
    drive_cycle(ALLRED_PAT, 1'b0);
    drive_cycle(ALLRED_PAT, 1'b1);
    n_checks++;
    if ({fault, fault_code, phase} !== {1'b0, 3'd0, 3'd7}) $display("FAIL prio_clear_wins: got %b want 0000111", {fault, fault_code, phase});
    else n_pass++;
    drive_cycle(ALLRED_PAT, 1'b0);
    n_checks++;
    if ({fault, fault_code} !== {1'b1, 3'd1}) $display("FAIL prio_reeval: got %b want 1001", {fault, fault_code});
    else n_pass++;
  endtask

  task automatic test_random();
    int p = 0;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      int r, len;
      logic [11:0] l;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        l = 12'($urandom);
        len = $urandom_range(1, 2);
      end else if (r < 10) begin
        l = 12'h000;
        len = $urandom_range(1, 3);
      end else begin
        if (r < 14) p = (p + 2) % 6;
        len = need(p);
        case ($urandom_range(0, 9))
          0: len = len - 1;
          1: len = len + 1;
          2: len = len + 2;
          default: ;
        endcase
        l = pat(p);
        p = (p + 1) % 6;
      end
      for (int k = 0; k < len; k++) begin
        drive_cycle(l, ($urandom_range(0, 19) == 0));
        n_checks++;
        if (act_vec !== exp_vec()) $display("FAIL random seg %0d: got %h want %h", seg, act_vec, exp_vec());
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_conflict();
    test_long();
    test_short_seq();
    test_off();
    test_async_reset();
    test_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tl_lamp_monitor.md
Name: tl_lamp_monitor

Overview:
- Passive checker on the lamp outputs of the four-approach traffic light controller (M1, MT, M2, S).
- Decodes the lamp pattern back into a phase number and locks onto the phase sequence.
- Verifies legal patterns, phase order and dwell times.
- Raises a sticky fault with a code for the safety/supervisor logic; never drives lamps.

Parameters:
- GREEN_CYCLES, 8, required samples of each green phase (P0, P2, P4).
- AMBER_CYCLES, 3, required samples of each amber phase (P1, P3, P5).
- CNT_W, 5, dwell counter width; GREEN_CYCLES and AMBER_CYCLES must be ≤ 2^CNT_W-2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m1  in  3  main-1 lamp code
- mt  in  3  main-turn lamp code
- m2  in  3  main-2 lamp code
- s  in  3  side lamp code
- clr_fault  in  1  sync clear of sticky fault
- phase  out  3  decoded current phase 0..5; 7 when unknown
- locked  out  1  sequence verified
- phase_change  out  1  1-cycle pulse on accepted successor transition
- fault  out  1  sticky fault
- fault_code  out  3  first fault: 0 none, 1 ILLEGAL, 2 CONFLICT, 3 SEQUENCE, 4 SHORT, 5 LONG
- conflict  out  1  registered instantaneous conflicting-green flag
- dwell  out  CNT_W  consecutive samples of current pattern

Behaviour:
- Lamp codes: 001 GREEN, 010 AMBER, 100 RED, 000 OFF.
- Phase patterns, as {m1, mt, m2, s}:
  - P0 = G,R,G,R
  - P1 = G,R,A,R
  - P2 = G,G,R,R
  - P3 = A,A,R,R
  - P4 = R,R,R,G
  - P5 = R,R,R,A
- All four lamps 000 = OFF. Any other combination = ILLEGAL.
- CONFLICT = s non-RED while any of m1/mt/m2 non-RED, or mt non-RED while m2 non-RED. CONFLICT is a subset of ILLEGAL and takes precedence in the code.
- Latency and sampling:
  - Lamp inputs are registered at every edge.
  - The decoder and FSM act on the registered sample at the following edge.
  - Every output reflects the lamp value sampled one edge earlier, giving 2-edge latency from the lamp change.
- Dwell counter:
  - Set to 1 on the first sample of a new pattern.
  - Increments on each repeat sample; saturates at all-ones.
  - Expected dwell = GREEN_CYCLES for even phases, AMBER_CYCLES for odd phases.
- FSM states IDLE, SYNC, LOCKED, FAULT:
  - IDLE: phase=7, locked=0. First legal phase → SYNC, phase updated. OFF → stay.
  - SYNC: change to successor ((p+1) mod 6) → LOCKED with phase_change=1. The dwell of the sync phase is NOT checked, because the first phase after controller reset runs one cycle long.
  - LOCKED, on a change to successor: check the old dwell; dwell < expected → SHORT. Otherwise phase_change=1.
  - LOCKED, on the same pattern: dwell == expected and another repeat sample → LONG, flagged on sample expected+1.
  - SYNC/LOCKED, change to a non-successor legal phase → SEQUENCE.
  - Any state except FAULT: ILLEGAL/CONFLICT pattern → FAULT.
  - SYNC/LOCKED, OFF sample → IDLE with no fault (controller reset).
  - FAULT: sticky; fault=1, locked=0, phase frozen at the last legal value, fault_code holds the first fault. clr_fault → IDLE, with fault and fault_code cleared.
- Simultaneous events:
  - Code priority: CONFLICT > ILLEGAL > SEQUENCE > SHORT > LONG.
  - clr_fault beats a new fault in the same cycle; the new pattern is re-evaluated from IDLE next sample.
- conflict output: updated every sample regardless of state, including FAULT.
- Reset values: all input sample registers 000; state IDLE; phase=7; locked=0; phase_change=0; fault=0; fault_code=0; conflict=0; dwell=0.
- Reset mid-operation: rst asserted mid-operation returns to these values immediately (asynchronous).

Decomposition:
- Package tl_pkg holds:
  - lamp code constants (GREEN/AMBER/RED/OFF)
  - phase ids P0..P5 and PHASE_NONE=7
  - fault code constants
  - FSM state typedef
  - the 6-entry phase-pattern table (12-bit words)
- Sub-module tl_pattern_decode: combinational; 12 lamp bits → phase[2:0], legal, off, conflict.
- The FSM, dwell counter and fault logic stay in tl_lamp_monitor.

Test Plan:
- Nominal lock-in: rst, then drive nominal sequence P0×9, P1×3, P2×8, P3×3, P4×8, P5×3, P0×8 repeating for 3 rounds → locked=1 after the first P0→P1 change; phase_change pulses 6 per round; fault=0; phase tracks 0..5.
- Conflict: while LOCKED in P4, drive m1=001, s=001 → conflict=1, fault=1, fault_code=2, locked=0; stays latched until clr_fault → IDLE, fault_code=0.
- Long dwell: LOCKED, hold P2 for 9 samples → fault_code=5 flagged on sample 9; hold P1 for 4 → fault_code=5.
- Short dwell and sequence: LOCKED, P0 for 7 samples then P1 → fault_code=4. Separate run: P1 then P3 → fault_code=3.
- Reset / OFF:
  - LOCKED, then all lamps 000 for 2 samples → IDLE, locked=0, fault=0; relock on the next legal sequence.
  - Assert rst mid-P2 → every output at its reset value without waiting for an edge.
- Priority: in FAULT with code 4, present a CONFLICT pattern → fault_code stays 4. Assert clr_fault together with an ILLEGAL pattern → IDLE this cycle, fault_code=1 on the next sample.
